// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg -- shared definitions for the ALU reservation station.
//   TAG_W_DEF : default ROB-tag width
//   DATA_W    : operand / result width
//   alu_op_e  : shared ALU opcode set
package alu_rs_pkg;
  localparam int TAG_W_DEF = 4;
  localparam int DATA_W    = 32;

  // Compares are unsigned. Lthan/Lequal test op1 < / <= op2 and
  // Rthan/Requal test op1 > / >= op2. Shifts are logical and use op2[4:0].
  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_OR     = 4'd2,
    OP_XOR    = 4'd3,
    OP_LSHIFT = 4'd4,
    OP_RSHIFT = 4'd5,
    OP_LTHAN  = 4'd6,
    OP_LEQUAL = 4'd7,
    OP_RTHAN  = 4'd8,
    OP_REQUAL = 4'd9
  } alu_op_e;

  // Zero-extend a compare flag to a full data word.
  function automatic logic [DATA_W-1:0] flag_w(input logic b);
    return {{(DATA_W-1){1'b0}}, b};
  endfunction
endpackage

// File: rtl/alu_rs_if.sv
// alu_rs_if -- dispatch, CDB snoop and result broadcast bundle.
//   disp_*  : dispatch request (valid, op, operands, pending tags, dest)
//   full    : station has no free entry
//   cdb_*   : external result broadcast snooped for wakeup
//   res_*   : this unit's registered result broadcast
// master = producer of dispatch/CDB (front end); slave = the station.
interface alu_rs_if import alu_rs_pkg::*; #(parameter int TAG_W = TAG_W_DEF);
  logic              disp_valid;
  logic [3:0]        disp_op;
  logic [DATA_W-1:0] disp_v1;
  logic [DATA_W-1:0] disp_v2;
  logic              disp_q1_busy;
  logic              disp_q2_busy;
  logic [TAG_W-1:0]  disp_q1;
  logic [TAG_W-1:0]  disp_q2;
  logic [TAG_W-1:0]  disp_dest;
  logic              full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              res_valid;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res_value;

  modport master (
    output disp_valid, disp_op, disp_v1, disp_v2, disp_q1_busy, disp_q2_busy,
           disp_q1, disp_q2, disp_dest, cdb_valid, cdb_tag, cdb_value,
    input  full, res_valid, res_tag, res_value
  );
  modport slave (
    input  disp_valid, disp_op, disp_v1, disp_v2, disp_q1_busy, disp_q2_busy,
           disp_q1, disp_q2, disp_dest, cdb_valid, cdb_tag, cdb_value,
    output full, res_valid, res_tag, res_value
  );
endinterface

// File: rtl/alu_rs_alu.sv
// alu_rs_alu -- combinational 32-bit ALU on the shared opcode set.
//   i_op  : opcode (alu_op_e encoding); unknown opcodes give 0
//   i_a   : operand 1
//   i_b   : operand 2
//   o_res : result; compares yield 0 or 1
module alu_rs_alu import alu_rs_pkg::*; (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_res
);
  always_comb begin
    o_res = '0;
    case (i_op)
      OP_ADD:    o_res = i_a + i_b;
      OP_SUB:    o_res = i_a - i_b;
      OP_OR:     o_res = i_a | i_b;
      OP_XOR:    o_res = i_a ^ i_b;
      OP_LSHIFT: o_res = i_a << i_b[4:0];
      OP_RSHIFT: o_res = i_a >> i_b[4:0];
      OP_LTHAN:  o_res = flag_w(i_a <  i_b);
      OP_LEQUAL: o_res = flag_w(i_a <= i_b);
      OP_RTHAN:  o_res = flag_w(i_a >  i_b);
      OP_REQUAL: o_res = flag_w(i_a >= i_b);
      default:   o_res = '0;
    endcase
  end
endmodule

// File: rtl/alu_rs.sv
// alu_rs -- ALU reservation station with inline wakeup/select and one
// registered result broadcast per cycle.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-low reset
//   i_rdy : global ready, low freezes the station
//   i_clr : mispredict flush (beats i_rdy, loses to i_rst)
//   bus   : alu_rs_if.slave -- dispatch, full, CDB snoop, result broadcast
module alu_rs import alu_rs_pkg::*; #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_rdy,
  input  logic    i_clr,
  alu_rs_if.slave bus
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic              busy;
    logic [3:0]        op;
    logic [DATA_W-1:0] v1;
    logic [TAG_W-1:0]  q1;
    logic              q1b;
    logic [DATA_W-1:0] v2;
    logic [TAG_W-1:0]  q2;
    logic              q2b;
    logic [TAG_W-1:0]  dest;
  } ent_t;

  typedef struct packed {
    logic              busy;
    logic [DATA_W-1:0] val;
  } opnd_t;

  ent_t               r_ent [RS_SIZE];
  ent_t               w_nxt [RS_SIZE];
  logic               r_res_valid;
  logic [TAG_W-1:0]   r_res_tag;
  logic [DATA_W-1:0]  r_res_value;
  logic [RS_SIZE-1:0] w_busy;
  logic [RS_SIZE-1:0] w_ready;
  logic               w_full;
  logic               w_free_hit;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_sel_hit;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [DATA_W-1:0]  w_alu_res;

  // Per-entry status flags; ready means busy with both operands present.
  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    assign w_busy[g]  = r_ent[g].busy;
    assign w_ready[g] = r_ent[g].busy & ~r_ent[g].q1b & ~r_ent[g].q2b;
  end

  // full and select look only at registered state, so a freed entry
  // becomes visible to dispatch one cycle later.
  assign w_full = &w_busy;

  always_comb begin
    w_free_hit = 1'b0;
    w_free_idx = '0;
    w_sel_hit  = 1'b0;
    w_sel_idx  = '0;
    // Scan downwards so the lowest index is the last one written.
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!w_busy[i]) begin
        w_free_hit = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (w_ready[i]) begin
        w_sel_hit = 1'b1;
        w_sel_idx = IDX_W'(i);
      end
    end
  end

  alu_rs_alu u_alu (
    .i_op  (r_ent[w_sel_idx].op),
    .i_a   (r_ent[w_sel_idx].v1),
    .i_b   (r_ent[w_sel_idx].v2),
    .o_res (w_alu_res)
  );

  // Snoop both broadcasts for a pending operand; the external CDB wins if
  // both happen to carry the same tag.
  function automatic opnd_t snoop(input logic pend, input logic [TAG_W-1:0] q,
                                  input logic [DATA_W-1:0] v);
    opnd_t o;
    o = '{busy: pend, val: v};
    if (pend && bus.cdb_valid && q == bus.cdb_tag)
      o = '{busy: 1'b0, val: bus.cdb_value};
    else if (pend && r_res_valid && q == r_res_tag)
      o = '{busy: 1'b0, val: r_res_value};
    return o;
  endfunction

  always_comb begin
    opnd_t o1, o2;
    o1    = '0;
    o2    = '0;
    w_nxt = r_ent;
    for (int i = 0; i < RS_SIZE; i++) begin
      o1 = snoop(r_ent[i].busy & r_ent[i].q1b, r_ent[i].q1, r_ent[i].v1);
      o2 = snoop(r_ent[i].busy & r_ent[i].q2b, r_ent[i].q2, r_ent[i].v2);
      w_nxt[i].q1b = o1.busy;
      w_nxt[i].v1  = o1.val;
      w_nxt[i].q2b = o2.busy;
      w_nxt[i].v2  = o2.val;
    end
    if (w_sel_hit) w_nxt[w_sel_idx].busy = 1'b0;
    // The free slot is never the selected one (free = !busy), so no clash.
    if (bus.disp_valid && !w_full && w_free_hit) begin
      o1 = snoop(bus.disp_q1_busy, bus.disp_q1, bus.disp_v1);
      o2 = snoop(bus.disp_q2_busy, bus.disp_q2, bus.disp_v2);
      w_nxt[w_free_idx] = '{busy: 1'b1, op: bus.disp_op,
                            v1: o1.val, q1: bus.disp_q1, q1b: o1.busy,
                            v2: o2.val, q2: bus.disp_q2, q2b: o2.busy,
                            dest: bus.disp_dest};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
      r_res_valid <= 1'b0;
      r_res_tag   <= '0;
      r_res_value <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < RS_SIZE; i++) r_ent[i].busy <= 1'b0;
      r_res_valid <= 1'b0;
    end else if (i_rdy) begin
      for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= w_nxt[i];
      r_res_valid <= w_sel_hit;
      if (w_sel_hit) begin
        r_res_tag   <= r_ent[w_sel_idx].dest;
        r_res_value <= w_alu_res;
      end
    end else begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.full      = w_full;
  assign bus.res_valid = r_res_valid;
  assign bus.res_tag   = r_res_tag;
  assign bus.res_value = r_res_value;
endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;
  import alu_rs_pkg::*;
  localparam int RS = 8;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic clr = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_rs_if #(.TAG_W(TW)) bus();
  alu_rs #(.RS_SIZE(RS), .TAG_W(TW)) dut (
    .i_clk(clk), .i_rst(rst), .i_rdy(rdy), .i_clr(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: the station as a table of waiting instructions.
  bit          m_busy [RS];
  logic [3:0]  m_op   [RS];
  logic [31:0] m_v1   [RS];
  logic [31:0] m_v2   [RS];
  bit          m_p1   [RS];
  bit          m_p2   [RS];
  logic [TW-1:0] m_q1 [RS];
  logic [TW-1:0] m_q2 [RS];
  logic [TW-1:0] m_dest [RS];
  bit          m_rv   = 1'b0;
  logic [TW-1:0] m_rt = '0;
  logic [31:0] m_rval = '0;

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a | b;
      3: return a ^ b;
      4: return a << sh;
      5: return a >> sh;
      6: return (a <  b) ? 32'd1 : 32'd0;
      7: return (a <= b) ? 32'd1 : 32'd0;
      8: return (a >  b) ? 32'd1 : 32'd0;
      9: return (a >= b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Does a broadcast visible this cycle carry tag t? Returns its value.
  function automatic bit bcast(input logic [TW-1:0] t, output logic [31:0] v);
    v = '0;
    if (bus.cdb_valid && bus.cdb_tag == t) begin v = bus.cdb_value; return 1'b1; end
    if (m_rv && m_rt == t) begin v = m_rval; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < RS; i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update();
    int sel, free;
    bit nrv;
    logic [TW-1:0] nrt;
    logic [31:0] nrval, v;
    if (!rst) begin
      for (int i = 0; i < RS; i++) m_busy[i] = 1'b0;
      m_rv = 1'b0; m_rt = '0; m_rval = '0;
      return;
    end
    if (clr) begin
      for (int i = 0; i < RS; i++) m_busy[i] = 1'b0;
      m_rv = 1'b0;
      return;
    end
    if (!rdy) begin m_rv = 1'b0; return; end
    sel = -1; free = -1;
    for (int i = 0; i < RS; i++) begin
      if (free < 0 && !m_busy[i]) free = i;
      if (sel < 0 && m_busy[i] && !m_p1[i] && !m_p2[i]) sel = i;
    end
    nrv = (sel >= 0); nrt = m_rt; nrval = m_rval;
    if (sel >= 0) begin
      nrt = m_dest[sel];
      nrval = ref_alu(int'(m_op[sel]), m_v1[sel], m_v2[sel]);
      m_busy[sel] = 1'b0;
    end
    for (int i = 0; i < RS; i++) if (m_busy[i]) begin
      if (m_p1[i] && bcast(m_q1[i], v)) begin m_p1[i] = 1'b0; m_v1[i] = v; end
      if (m_p2[i] && bcast(m_q2[i], v)) begin m_p2[i] = 1'b0; m_v2[i] = v; end
    end
    if (bus.disp_valid && free >= 0) begin
      m_busy[free] = 1'b1; m_op[free] = bus.disp_op; m_dest[free] = bus.disp_dest;
      m_v1[free] = bus.disp_v1; m_q1[free] = bus.disp_q1; m_p1[free] = bus.disp_q1_busy;
      m_v2[free] = bus.disp_v2; m_q2[free] = bus.disp_q2; m_p2[free] = bus.disp_q2_busy;
      if (m_p1[free] && bcast(m_q1[free], v)) begin m_p1[free] = 1'b0; m_v1[free] = v; end
      if (m_p2[free] && bcast(m_q2[free], v)) begin m_p2[free] = 1'b0; m_v2[free] = v; end
    end
    m_rv = nrv; m_rt = nrt; m_rval = nrval;
  endtask

  // One clock: model consumes the inputs seen at the edge; outputs read 1ns later.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0; bus.disp_op = '0; bus.disp_v1 = '0; bus.disp_v2 = '0;
    bus.disp_q1_busy = 1'b0; bus.disp_q2_busy = 1'b0; bus.disp_q1 = '0; bus.disp_q2 = '0;
    bus.disp_dest = '0; bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_value = '0;
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [31:0] v1, input bit p1,
                          input logic [TW-1:0] q1, input logic [31:0] v2, input bit p2,
                          input logic [TW-1:0] q2, input logic [TW-1:0] dest);
    bus.disp_valid = 1'b1; bus.disp_op = op; bus.disp_dest = dest;
    bus.disp_v1 = v1; bus.disp_q1_busy = p1; bus.disp_q1 = q1;
    bus.disp_v2 = v2; bus.disp_q2_busy = p2; bus.disp_q2 = q2;
  endtask

  task automatic set_cdb(input logic [TW-1:0] t, input logic [31:0] v);
    bus.cdb_valid = 1'b1; bus.cdb_tag = t; bus.cdb_value = v;
  endtask

  task automatic drain();
    idle(); step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); step(); step();
    n_chk++;
    if (bus.res_valid !== 1'b0 || bus.res_tag !== 4'd0 || bus.res_value !== 32'd0) begin
      n_fail++; $display("FAIL reset_res: valid=%b tag=%0d val=%0h expected 0/0/0", bus.res_valid, bus.res_tag, bus.res_value);
    end
    n_chk++;
    if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    rst = 1'b1;
  endtask

  task automatic test_add();
    drain();
    set_disp(OP_ADD, 5, 0, 0, 7, 0, 0, 3); step(); idle();
    n_chk++;
    if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL add_early: valid=%b expected 0", bus.res_valid); end
    step();
    n_chk++;
    if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd3 || bus.res_value !== 32'd12) begin
      n_fail++; $display("FAIL add_res: valid=%b tag=%0d val=%0d expected 1/3/12", bus.res_valid, bus.res_tag, bus.res_value);
    end
    step();
    n_chk++;
    if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL add_pulse: valid=%b expected 0", bus.res_valid); end
  endtask

  task automatic test_cdb_wakeup();
    bit seen = 1'b0;
    drain();
    set_disp(OP_SUB, 0, 1, 6, 1, 0, 0, 2); step(); idle();   // cycle 1
    seen |= bus.res_valid; step();                          // cycle 2
    seen |= bus.res_valid; step();                          // cycle 3
    seen |= bus.res_valid;
    set_cdb(6, 0);
    set_disp(OP_XOR, 3, 0, 0, 0, 1, 6, 7);                  // same-cycle bypass
    step(); idle();                                         // cycle 4
    seen |= bus.res_valid; step();                          // cycle 5
    n_chk++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL cdb_early: spurious res_valid before cycle 5"); end
    n_chk++;
    if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd2 || bus.res_value !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL cdb_res: valid=%b tag=%0d val=%0h expected 1/2/ffffffff", bus.res_valid, bus.res_tag, bus.res_value);
    end
    step();
    n_chk++;
    if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd7 || bus.res_value !== 32'd3) begin
      n_fail++; $display("FAIL cdb_bypass: valid=%b tag=%0d val=%0h expected 1/7/3", bus.res_valid, bus.res_tag, bus.res_value);
    end
  endtask

  task automatic test_dependent();
    drain();
    set_disp(OP_ADD, 1, 0, 0, 1, 0, 0, 1); step();
    set_disp(OP_LTHAN, 0, 1, 1, 3, 0, 0, 4); step(); idle();  // cycle 2
    n_chk++;
    if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd1 || bus.res_value !== 32'd2) begin
      n_fail++; $display("FAIL dep_first: valid=%b tag=%0d val=%0d expected 1/1/2", bus.res_valid, bus.res_tag, bus.res_value);
    end
    step();
    n_chk++;
    if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL dep_gap: valid=%b expected 0", bus.res_valid); end
    step();
    n_chk++;
    if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd4 || bus.res_value !== 32'd1) begin
      n_fail++; $display("FAIL dep_second: valid=%b tag=%0d val=%0d expected 1/4/1", bus.res_valid, bus.res_tag, bus.res_value);
    end
  endtask

  task automatic test_full();
    int cnt = 0;
    drain();
    for (int i = 0; i < RS; i++) begin
      set_disp(OP_ADD, 0, 1, (i == 0) ? 4'd5 : 4'd7, i, 0, 0, 4'(i)); step();
    end
    n_chk++;
    if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b expected 1", bus.full); end
    set_disp(OP_ADD, 0, 1, 7, 50, 0, 0, 15); step(); idle();   // 9th, ignored
    n_chk++;
    if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_hold: got %b expected 1", bus.full); end
    set_cdb(5, 10); step(); idle();                             // C+1: entry 0 issues
    n_chk++;
    if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_issue_cycle: got %b expected 1", bus.full); end
    set_disp(OP_ADD, 1, 0, 0, 1, 0, 0, 14); step(); idle();     // C+2: dropped, still full
    n_chk++;
    if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd0 || bus.res_value !== 32'd10 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL full_wake: valid=%b tag=%0d val=%0d full=%b expected 1/0/10/0", bus.res_valid, bus.res_tag, bus.res_value, bus.full);
    end
    set_disp(OP_ADD, 20, 0, 0, 22, 0, 0, 9); step(); idle();    // lands in entry 0
    n_chk++;
    if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_reuse: got %b expected 1", bus.full); end
    step();
    n_chk++;
    if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd9 || bus.res_value !== 32'd42) begin
      n_fail++; $display("FAIL full_reuse_res: valid=%b tag=%0d val=%0d expected 1/9/42", bus.res_valid, bus.res_tag, bus.res_value);
    end
    set_cdb(7, 100); step(); idle();
    for (int k = 0; k < 12; k++) begin
      if (bus.res_valid === 1'b1) begin
        cnt++;
        n_chk++;
        if (bus.res_tag !== 4'(cnt) || bus.res_value !== 32'(100 + cnt)) begin
          n_fail++; $display("FAIL full_drain: tag=%0d val=%0d expected %0d/%0d", bus.res_tag, bus.res_value, cnt, 100 + cnt);
        end
      end
      step();
    end
    n_chk++;
    if (cnt != 7) begin n_fail++; $display("FAIL full_drain_count: got %0d results expected 7", cnt); end
  endtask

  task automatic test_stall();
    drain();
    set_disp(OP_XOR, 32'hF0F0_0000, 0, 0, 32'h0000_FFFF, 0, 0, 5); step(); idle();
    rdy = 1'b0;
    set_disp(OP_ADD, 1, 0, 0, 2, 0, 0, 6); set_cdb(5, 32'h1234);
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL stall_quiet: valid=%b expected 0", bus.res_valid); end
    end
    rdy = 1'b1; idle();
    n_chk++;
    if (bus.full !== 1'b0) begin n_fail++; $display("FAIL stall_full: got %b expected 0", bus.full); end
    step();
    n_chk++;
    if (bus.res_valid !== 1'b1 || bus.res_tag !== 4'd5 || bus.res_value !== 32'hF0F0_FFFF) begin
      n_fail++; $display("FAIL stall_resume: valid=%b tag=%0d val=%0h expected 1/5/f0f0ffff", bus.res_valid, bus.res_tag, bus.res_value);
    end
    step(); step();
    n_chk++;
    if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dropped_disp: valid=%b expected 0", bus.res_valid); end
  endtask

  task automatic test_clr_rst();
    bit seen = 1'b0;
    drain();
    for (int i = 0; i < RS; i++) begin set_disp(OP_OR, i, 1, 7, 0, 0, 0, 4'(i)); step(); end
    idle(); clr = 1'b1; step(); clr = 1'b0;
    n_chk++;
    if (bus.full !== 1'b0 || bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_state: full=%b valid=%b expected 0/0", bus.full, bus.res_valid);
    end
    set_cdb(7, 1); step(); idle();
    for (int k = 0; k < 5; k++) begin seen |= bus.res_valid; step(); end
    set_disp(OP_ADD, 1, 0, 0, 2, 0, 0, 3); step(); idle();
    clr = 1'b1; step(); clr = 1'b0;
    seen |= bus.res_valid; step();
    seen |= bus.res_valid;
    n_chk++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL clr_residual: res_valid seen after flush"); end
    set_disp(OP_ADD, 3, 0, 0, 4, 0, 0, 8); step();
    set_disp(OP_ADD, 0, 1, 9, 4, 0, 0, 10); rst = 1'b0; step(); rst = 1'b1; idle();
    n_chk++;
    if (bus.res_valid !== 1'b0 || bus.res_tag !== 4'd0 || bus.res_value !== 32'd0 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: valid=%b tag=%0d val=%0h full=%b expected 0/0/0/0", bus.res_valid, bus.res_tag, bus.res_value, bus.full);
    end
    seen = 1'b0;
    set_cdb(9, 5);
    for (int k = 0; k < 4; k++) begin step(); idle(); seen |= bus.res_valid; end
    n_chk++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_residual: res_valid seen after reset"); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rdy = ($urandom_range(9) != 0);
      clr = ($urandom_range(39) == 0);
      rst = ($urandom_range(299) != 0);
      bus.disp_valid   = $urandom_range(1);
      bus.disp_op      = 4'($urandom_range(15));
      bus.disp_v1      = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(7));
      bus.disp_v2      = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(7));
      bus.disp_q1_busy = $urandom_range(1);
      bus.disp_q2_busy = ($urandom_range(2) == 0);
      bus.disp_q1      = 4'($urandom_range(15));
      bus.disp_q2      = 4'($urandom_range(15));
      bus.disp_dest    = 4'($urandom_range(15));
      bus.cdb_valid    = ($urandom_range(2) == 0);
      bus.cdb_tag      = 4'($urandom_range(15));
      bus.cdb_value    = ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(7));
      step();
      n_chk++;
      if (bus.res_valid !== m_rv) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, bus.res_valid, m_rv); end
      n_chk++;
      if (bus.res_tag !== m_rt || bus.res_value !== m_rval) begin
        n_fail++; $display("FAIL rnd_res c%0d: tag=%0d val=%0h expected %0d/%0h", c, bus.res_tag, bus.res_value, m_rt, m_rval);
      end
      n_chk++;
      if (bus.full !== model_full()) begin n_fail++; $display("FAIL rnd_full c%0d: got %b expected %b", c, bus.full, model_full()); end
    end
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_add();
    test_cdb_wakeup();
    test_dependent();
    test_full();
    test_stall();
    test_clr_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
